// File: rtl/sequential_alu.sv
// -----------------------------------------------------------------------------
// sequential_alu
//
// Execute-stage ALU driven by the 4-bit ALUOperation code from the ALU control
// decoder. Logic/arithmetic ops, LUI and JR complete on the cycle after start.
// SLL/SRL use an iterative one-bit-per-cycle shifter and hold busy high while
// shifting, so the core stalls until done.
//
// Build option:
//   SEQUENTIAL_ALU_BARREL_EN  - when defined, SLL/SRL use a combinational
//                               barrel shifter; every op is single-cycle and
//                               busy is tied low.
//
// Ports:
//   clk           in   rising-edge clock
//   reset         in   asynchronous, active-high reset
//   start         in   operation request, sampled only in IDLE
//   ALUOperation  in   [3:0] op code (see localparams below)
//   A             in   [DATA_WIDTH-1:0] operand rs
//   B             in   [DATA_WIDTH-1:0] operand rt / immediate
//   shamt         in   [SHAMT_WIDTH-1:0] shift amount
//   busy          out  high while an iterative shift is in progress
//   done          out  one-cycle pulse, result valid
//   ALUResult     out  [DATA_WIDTH-1:0] registered result, held until next done
//   Zero          out  registered (ALUResult == 0)
//   Error         out  registered, high with done for an invalid op code
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start; single-cycle ops complete from here
// SHIFT | iterative SLL/SRL, one bit per clock until cnt reaches zero
// -----------------------------------------------------------------------------
module sequential_alu #(
  parameter int DATA_WIDTH  = 32,
  parameter int SHAMT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [3:0]             ALUOperation,
  input  logic [DATA_WIDTH-1:0]  A,
  input  logic [DATA_WIDTH-1:0]  B,
  input  logic [SHAMT_WIDTH-1:0] shamt,
  output logic                   busy,
  output logic                   done,
  output logic [DATA_WIDTH-1:0]  ALUResult,
  output logic                   Zero,
  output logic                   Error
);

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;
  localparam logic [3:0] OP_JR  = 4'b1111;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [DATA_WIDTH-1:0]  shreg_q, shreg_d;
  logic [SHAMT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   left_q, left_d;
  logic [DATA_WIDTH-1:0]  result_q, result_d;
  logic                   zero_q, zero_d;
  logic                   error_q, error_d;
  logic                   done_q, done_d;

  logic [DATA_WIDTH-1:0]  single_res;
  logic                   single_err;
  logic                   is_shift_op;
  logic                   start_iter;
  logic [DATA_WIDTH-1:0]  shreg_step;

  assign is_shift_op = (ALUOperation == OP_SLL) || (ALUOperation == OP_SRL);

`ifdef SEQUENTIAL_ALU_BARREL_EN
  assign start_iter = 1'b0;
  assign busy       = 1'b0;
`else
  // A zero shift amount has nothing to iterate, so it takes the single-cycle path.
  assign start_iter = is_shift_op && (shamt != '0);
  assign busy       = (state_q == SHIFT);
`endif

  // Result of every op that completes directly from IDLE.
  always_comb begin
    single_res = '0;
    single_err = 1'b0;
    case (ALUOperation)
      OP_AND: single_res = A & B;
      OP_OR:  single_res = A | B;
      OP_NOR: single_res = ~(A | B);
      OP_ADD: single_res = A + B;
      OP_SUB: single_res = A - B;
`ifdef SEQUENTIAL_ALU_BARREL_EN
      OP_SLL: single_res = B << shamt;
      OP_SRL: single_res = B >> shamt;
`else
      // Only reached with shamt == 0 here; nonzero amounts go to SHIFT.
      OP_SLL: single_res = B;
      OP_SRL: single_res = B;
`endif
      OP_LUI: single_res = {B[15:0], {(DATA_WIDTH-16){1'b0}}};
      OP_JR:  single_res = A;
      default: begin
        single_res = '0;
        single_err = 1'b1;
      end
    endcase
  end

  assign shreg_step = left_q ? {shreg_q[DATA_WIDTH-2:0], 1'b0}
                             : {1'b0, shreg_q[DATA_WIDTH-1:1]};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
      left_q   <= 1'b0;
      result_q <= '0;
      zero_q   <= 1'b1;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
      left_q   <= left_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      error_q  <= error_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
    left_d   = left_q;
    result_d = result_q;
    zero_d   = zero_q;
    error_d  = error_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (start_iter) begin
            // Operands are captured here; later changes on A/B/op are ignored.
            shreg_d = B;
            cnt_d   = shamt;
            left_d  = (ALUOperation == OP_SLL);
            state_d = SHIFT;
          end else begin
            result_d = single_res;
            zero_d   = (single_res == '0);
            error_d  = single_err;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        // start is not sampled here, so requests during a shift are dropped.
        shreg_d = shreg_step;
        cnt_d   = cnt_q - SHAMT_WIDTH'(1);
        if (cnt_q == SHAMT_WIDTH'(1)) begin
          result_d = shreg_step;
          zero_d   = (shreg_step == '0);
          error_d  = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign done      = done_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;
  assign Error     = error_q;

endmodule

// File: tb/tb_sequential_alu.sv
module tb_sequential_alu;

  localparam logic [3:0] OP_AND = 4'b0000;
  localparam logic [3:0] OP_OR  = 4'b0001;
  localparam logic [3:0] OP_NOR = 4'b0010;
  localparam logic [3:0] OP_ADD = 4'b0011;
  localparam logic [3:0] OP_SUB = 4'b0100;
  localparam logic [3:0] OP_SLL = 4'b0101;
  localparam logic [3:0] OP_SRL = 4'b0110;
  localparam logic [3:0] OP_LUI = 4'b0111;
  localparam logic [3:0] OP_JR  = 4'b1111;
  localparam logic [3:0] OP_BAD = 4'b1001;

`ifdef SEQUENTIAL_ALU_BARREL_EN
  localparam bit BARREL = 1'b1;
`else
  localparam bit BARREL = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [3:0]  op;
  logic [31:0] a, b;
  logic [4:0]  sh;
  logic        busy, done, zero, err;
  logic [31:0] res;

  sequential_alu #(.DATA_WIDTH(32), .SHAMT_WIDTH(5)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .ALUOperation (op),
    .A            (a),
    .B            (b),
    .shamt        (sh),
    .busy         (busy),
    .done         (done),
    .ALUResult    (res),
    .Zero         (zero),
    .Error        (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int          cyc;
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   busy_lo = 0;
  int   busy_hi = -1;
  bit   mon_en  = 1'b0;

  function automatic void model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                                input logic [4:0] s, output logic [31:0] r, output logic e);
    e = 1'b0;
    case (o)
      OP_AND: r = x & y;
      OP_OR:  r = x | y;
      OP_NOR: r = ~(x | y);
      OP_ADD: r = x + y;
      OP_SUB: r = x - y;
      OP_SLL: r = y << s;
      OP_SRL: r = y >> s;
      OP_LUI: r = {y[15:0], 16'h0000};
      OP_JR:  r = x;
      default: begin r = 32'h0; e = 1'b1; end
    endcase
  endfunction

  // Drives one start for one cycle; the model decides whether the DUT accepts it.
  task automatic issue(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y, input logic [4:0] s);
    exp_t        ex;
    logic [31:0] r;
    logic        e;
    int          edge_n;
    op = o; a = x; b = y; sh = s; start = 1'b1;
    edge_n = cyc + 1;
    if (!(cyc >= busy_lo && cyc <= busy_hi)) begin
      model(o, x, y, s, r, e);
      ex.res = r;
      ex.err = e;
      if ((o == OP_SLL || o == OP_SRL) && s != 0 && !BARREL) begin
        busy_lo = edge_n;
        busy_hi = edge_n + int'(s) - 1;
        ex.cyc  = edge_n + int'(s);
      end else begin
        ex.cyc = edge_n;
      end
      sb.push_back(ex);
    end
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() > 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    if (sb.size() > 0) begin
      check_val("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  exp_t mon_x;
  logic mon_exp_done;
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      check_val("busy", busy, (cyc >= busy_lo && cyc <= busy_hi));
      while (sb.size() > 0 && sb[0].cyc < cyc) begin
        check_val("missed_done_cycle", cyc, sb[0].cyc);
        void'(sb.pop_front());
      end
      mon_exp_done = (sb.size() > 0) && (sb[0].cyc == cyc);
      check_val("done", done, mon_exp_done);
      if (mon_exp_done) begin
        mon_x = sb.pop_front();
        check_val("result", res, mon_x.res);
        check_val("zero", zero, (mon_x.res == 32'h0));
        check_val("error", err, mon_x.err);
      end
    end
  end

  logic [3:0] op_tab [10];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    op_tab = '{OP_AND, OP_OR, OP_NOR, OP_ADD, OP_SUB, OP_SLL, OP_SRL, OP_LUI, OP_JR, OP_BAD};
    reset = 1'b1; start = 1'b0; op = 4'h0; a = '0; b = '0; sh = '0;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    check_val("rst_result", res, 0);
    check_val("rst_zero", zero, 1);
    check_val("rst_error", err, 0);
    reset = 1'b0;
    mon_en = 1'b1;
    @(posedge clk); #1;

    // back-to-back single-cycle ops
    issue(OP_ADD, 32'hFFFFFFFF, 32'h1, 5'd0);
    issue(OP_SUB, 32'd5, 32'd3, 5'd0);
    issue(OP_NOR, 32'h0, 32'h0, 5'd0);
    issue(OP_AND, 32'hF0F0_1234, 32'h0FF0_FFFF, 5'd0);
    issue(OP_OR,  32'h1200_0000, 32'h0000_0034, 5'd0);
    drain();

    // iterative shifts and shamt=0
    issue(OP_SLL, 32'h0, 32'h0000_0003, 5'd4);
    drain();
    issue(OP_SRL, 32'h0, 32'h8000_0000, 5'd31);
    drain();
    issue(OP_SLL, 32'h0, 32'hDEAD_BEEF, 5'd0);
    issue(OP_SRL, 32'h0, 32'hCAFE_F00D, 5'd0);
    drain();
    issue(OP_SLL, 32'h0, 32'h8000_0001, 5'd1);
    drain();

    // start while busy must be dropped
    issue(OP_SRL, 32'h0, 32'hF000_0000, 5'd8);
    repeat (4) issue(OP_ADD, 32'd1, 32'd2, 5'd0);
    drain();

    // LUI / JR / invalid, then a valid op clears Error
    issue(OP_LUI, 32'h0, 32'h1234_ABCD, 5'd0);
    issue(OP_JR,  32'h0040_0020, 32'h0, 5'd0);
    issue(OP_BAD, 32'h1111_1111, 32'h2222_2222, 5'd0);
    issue(OP_ADD, 32'd1, 32'd1, 5'd0);
    issue(4'b1010, 32'h5, 32'h5, 5'd0);
    issue(OP_SLL, 32'h0, 32'h0000_0001, 5'd3);
    drain();

    // random mix, back-to-back, including requests that land during shifts
    for (int i = 0; i < 40; i++) begin
      logic [3:0] o;
      o = op_tab[$urandom_range(0, 9)];
      issue(o, $urandom, $urandom, 5'($urandom_range(0, 6)));
    end
    drain();

    // reset in the middle of a long shift
    issue(OP_SLL, 32'h0, 32'h0000_0001, 5'd20);
    repeat (4) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_done", done, 0);
    check_val("midrst_result", res, 0);
    check_val("midrst_zero", zero, 1);
    check_val("midrst_error", err, 0);
    sb.delete();
    busy_hi = -1;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    issue(OP_ADD, 32'd7, 32'd8, 5'd0);
    issue(OP_SLL, 32'h0, 32'h0000_0003, 5'd4);
    drain();
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
